// File: rtl/core_mem_stage.sv
// Memory stage: turns EX-stage loads/stores into a req/gnt/rvalid data-memory
// transaction and registers the results toward write-back.
module core_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic [3:0]      i_d_size,
  input  logic            i_d_unsigned,
  input  logic [2:0]      i_mem_to_reg,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc_plus_4,
  input  logic [4:0]      i_rd,
  input  logic            i_reg_write,
  output logic            o_stall,
  output logic            o_data_req,
  output logic            o_data_we,
  output logic [XLEN-1:0] o_data_addr,
  output logic [3:0]      o_data_be,
  output logic [XLEN-1:0] o_data_wdata,
  input  logic            i_data_gnt,
  input  logic            i_data_rvalid,
  input  logic [XLEN-1:0] i_data_rdata,
  output logic            o_wb_valid,
  output logic [3:0]      o_d_size,
  output logic            o_d_unsigned,
  output logic [2:0]      o_mem_to_reg,
  output logic [XLEN-1:0] o_data_rd_data,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_pc_plus_4,
  output logic [XLEN-1:0] o_alu_result,
  output logic [4:0]      o_rd,
  output logic            o_reg_write,
  output logic            o_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] addr_p1;
  logic [XLEN-1:0] rs2_p1;
  logic [XLEN-1:0] imm_p1;
  logic [XLEN-1:0] pc4_p1;
  logic            we_p1;
  logic [3:0]      size_p1;
  logic            uns_p1;
  logic [2:0]      m2r_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1;

  logic is_mem_in;
  logic mis_in;
  logic stall;
  logic latch_en;
  logic cmp_pass;
  logic cmp_lat;
  logic cmp_load;

  function automatic logic [3:0] lane_be(input logic [3:0] size, input logic [1:0] lo);
    case (size)
      4'b0001: lane_be = 4'b0001 << lo;
      4'b0011: lane_be = 4'b0011 << {lo[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [3:0] size,
                                                 input logic [XLEN-1:0] d);
    case (size)
      4'b0001: lane_wdata = {(XLEN/8){d[7:0]}};
      4'b0011: lane_wdata = {(XLEN/16){d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] lo);
    is_misaligned = ((size == 4'b0011) && lo[0]) || ((size == 4'b1111) && (lo != 2'b00));
  endfunction

  assign is_mem_in = i_mem_read | i_mem_write;
  assign mis_in    = is_mem_in & is_misaligned(i_d_size, i_alu_result[1:0]);

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    latch_en = 1'b0;
    cmp_pass = 1'b0;
    cmp_lat  = 1'b0;
    cmp_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (is_mem_in && !mis_in) begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = REQ;
          end else begin
            cmp_pass = 1'b1;
          end
        end
      end
      REQ: begin
        // A read+write op latched we_p1=1 and therefore completes as a store.
        if (i_data_gnt && we_p1) begin
          cmp_lat = 1'b1;
          state_d = IDLE;
        end else if (i_data_gnt) begin
          stall   = 1'b1;
          state_d = WAIT;
        end else begin
          stall = 1'b1;
        end
      end
      WAIT: begin
        if (i_data_rvalid) begin
          cmp_lat  = 1'b1;
          cmp_load = 1'b1;
          state_d  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must drop the stall immediately even while EX still presents a memory op.
  assign o_stall      = stall & i_rst_n;
  assign o_data_req   = (state_q == REQ);
  assign o_data_we    = o_data_req & we_p1;
  assign o_data_addr  = {addr_p1[XLEN-1:2], 2'b00};
  assign o_data_be    = o_data_req ? lane_be(size_p1, addr_p1[1:0]) : 4'b0000;
  assign o_data_wdata = o_data_req ? lane_wdata(size_p1, rs2_p1) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: request context captured from EX when the transaction starts
  always_ff @(posedge i_clk) begin
    if (latch_en) begin
      addr_p1 <= i_alu_result;
      rs2_p1  <= i_rs2_data;
      imm_p1  <= i_imm;
      pc4_p1  <= i_pc_plus_4;
      we_p1   <= i_mem_write;
      size_p1 <= i_d_size;
      uns_p1  <= i_d_unsigned;
      m2r_p1  <= i_mem_to_reg;
      rd_p1   <= i_rd;
      rw_p1   <= i_reg_write;
    end
  end

  // Stage p2: write-back side registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_valid     <= 1'b0;
      o_reg_write    <= 1'b0;
      o_d_size       <= '0;
      o_d_unsigned   <= 1'b0;
      o_mem_to_reg   <= '0;
      o_data_rd_data <= '0;
      o_imm          <= '0;
      o_pc_plus_4    <= '0;
      o_alu_result   <= '0;
      o_rd           <= '0;
      o_misaligned   <= 1'b0;
    end else begin
      o_wb_valid  <= cmp_pass | cmp_lat;
      o_reg_write <= (cmp_pass & i_reg_write & ~mis_in) | (cmp_lat & rw_p1);
      if (cmp_pass) begin
        o_d_size       <= i_d_size;
        o_d_unsigned   <= i_d_unsigned;
        o_mem_to_reg   <= i_mem_to_reg;
        o_data_rd_data <= '0;
        o_imm          <= i_imm;
        o_pc_plus_4    <= i_pc_plus_4;
        o_alu_result   <= i_alu_result;
        o_rd           <= i_rd;
        o_misaligned   <= mis_in;
      end else if (cmp_lat) begin
        // Load data goes out unshifted; WB picks lanes using o_alu_result[1:0].
        o_d_size       <= size_p1;
        o_d_unsigned   <= uns_p1;
        o_mem_to_reg   <= m2r_p1;
        o_data_rd_data <= cmp_load ? i_data_rdata : '0;
        o_imm          <= imm_p1;
        o_pc_plus_4    <= pc4_p1;
        o_alu_result   <= addr_p1;
        o_rd           <= rd_p1;
        o_misaligned   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_stage.sv
// Bench for core_mem_stage: directed vector table, hand sequences for reset and
// back-to-back traffic, and randomized ops checked against a behavioural model.
module tb_core_mem_stage;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_mem_read = 1'b0;
  logic            i_mem_write = 1'b0;
  logic [3:0]      i_d_size = '0;
  logic            i_d_unsigned = 1'b0;
  logic [2:0]      i_mem_to_reg = '0;
  logic [XLEN-1:0] i_alu_result = '0;
  logic [XLEN-1:0] i_rs2_data = '0;
  logic [XLEN-1:0] i_imm = '0;
  logic [XLEN-1:0] i_pc_plus_4 = '0;
  logic [4:0]      i_rd = '0;
  logic            i_reg_write = 1'b0;
  logic            o_stall;
  logic            o_data_req;
  logic            o_data_we;
  logic [XLEN-1:0] o_data_addr;
  logic [3:0]      o_data_be;
  logic [XLEN-1:0] o_data_wdata;
  logic            i_data_gnt = 1'b0;
  logic            i_data_rvalid = 1'b0;
  logic [XLEN-1:0] i_data_rdata = '0;
  logic            o_wb_valid;
  logic [3:0]      o_d_size;
  logic            o_d_unsigned;
  logic [2:0]      o_mem_to_reg;
  logic [XLEN-1:0] o_data_rd_data;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_pc_plus_4;
  logic [XLEN-1:0] o_alu_result;
  logic [4:0]      o_rd;
  logic            o_reg_write;
  logic            o_misaligned;

  core_mem_stage #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_d_size(i_d_size),
    .i_d_unsigned(i_d_unsigned), .i_mem_to_reg(i_mem_to_reg),
    .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_pc_plus_4(i_pc_plus_4), .i_rd(i_rd), .i_reg_write(i_reg_write),
    .o_stall(o_stall), .o_data_req(o_data_req), .o_data_we(o_data_we),
    .o_data_addr(o_data_addr), .o_data_be(o_data_be), .o_data_wdata(o_data_wdata),
    .i_data_gnt(i_data_gnt), .i_data_rvalid(i_data_rvalid), .i_data_rdata(i_data_rdata),
    .o_wb_valid(o_wb_valid), .o_d_size(o_d_size), .o_d_unsigned(o_d_unsigned),
    .o_mem_to_reg(o_mem_to_reg), .o_data_rd_data(o_data_rd_data), .o_imm(o_imm),
    .o_pc_plus_4(o_pc_plus_4), .o_alu_result(o_alu_result), .o_rd(o_rd),
    .o_reg_write(o_reg_write), .o_misaligned(o_misaligned)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          rd_en;
    bit          wr_en;
    logic [3:0]  size;
    bit          uns;
    logic [2:0]  m2r;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rd;
    bit          rw;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    bit          noise;
  } op_t;

  typedef struct {
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          mis;
    int          stall;
    logic [31:0] rd_data;
    bit          rw;
  } exp_t;

  typedef struct {
    string name;
    op_t   op;
    exp_t  ex;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic op_t mk_op(input bit r, input bit w, input logic [3:0] size,
                                input logic [31:0] addr, input logic [31:0] rs2, input bit rw,
                                input int g, input int rv, input logic [31:0] rdata);
    op_t o;
    o.rd_en = r; o.wr_en = w; o.size = size; o.uns = addr[3]; o.m2r = 3'(addr[6:4]);
    o.addr = addr; o.rs2 = rs2; o.imm = addr ^ 32'h0F0F_1234; o.pc4 = addr + 32'h40;
    o.rd = addr[4:0] | 5'd1; o.rw = rw; o.gnt_dly = g; o.rv_dly = rv; o.rdata = rdata;
    o.noise = 1'b1;
    return o;
  endfunction

  function automatic exp_t mk_exp(input bit req, input bit we, input logic [31:0] addr,
                                  input logic [3:0] be, input logic [31:0] wdata, input bit mis,
                                  input int stall, input logic [31:0] rd_data, input bit rw);
    exp_t e;
    e.req = req; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.mis = mis;
    e.stall = stall; e.rd_data = rd_data; e.rw = rw;
    return e;
  endfunction

  // Reference behaviour from the stage's rules, expressed with plain arithmetic.
  function automatic exp_t model(input op_t o);
    exp_t e;
    bit is_mem, half, word;
    is_mem = o.rd_en || o.wr_en;
    half = (o.size == 4'b0011);
    word = (o.size == 4'b1111);
    e.mis = is_mem && ((half && (o.addr % 2 != 0)) || (word && (o.addr % 4 != 0)));
    e.req = is_mem && !e.mis;
    e.we = o.wr_en;
    e.addr = o.addr - (o.addr % 4);
    if (word) e.be = 4'hF;
    else if (half) e.be = 4'(3 << (o.addr & 2));
    else e.be = 4'(1 << (o.addr % 4));
    if (word) e.wdata = o.rs2;
    else if (half) e.wdata = (o.rs2 & 32'hFFFF) * 32'h0001_0001;
    else e.wdata = (o.rs2 & 32'hFF) * 32'h0101_0101;
    if (!e.req) e.stall = 0;
    else if (o.wr_en) e.stall = 1 + o.gnt_dly;
    else e.stall = 2 + o.gnt_dly + o.rv_dly;
    e.rd_data = (e.req && !o.wr_en) ? o.rdata : 32'h0;
    e.rw = o.rw && !e.mis;
    return e;
  endfunction

  task automatic drive_op(input op_t o);
    i_valid = 1'b1; i_mem_read = o.rd_en; i_mem_write = o.wr_en; i_d_size = o.size;
    i_d_unsigned = o.uns; i_mem_to_reg = o.m2r; i_alu_result = o.addr; i_rs2_data = o.rs2;
    i_imm = o.imm; i_pc_plus_4 = o.pc4; i_rd = o.rd; i_reg_write = o.rw;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_reg_write = 1'b0;
    i_data_gnt = 1'b0; i_data_rvalid = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic run_op(input string nm, input op_t o, input exp_t e, input bit gap);
    int req_seen = 0, wait_seen = 0, stall_cnt = 0, cyc = 0;
    bit in_wait = 0, done = 0, stable = 1, idle_zero = 1;
    logic [31:0] a0 = '0, w0 = '0;
    logic [3:0] b0 = '0;
    logic we0 = 1'b0;
    drive_op(o);
    i_data_rdata = o.rdata;
    while (!done && cyc < 60) begin
      i_data_gnt = 1'b0;
      i_data_rvalid = 1'b0;
      if (o_data_req) begin
        if (req_seen == 0) begin
          a0 = o_data_addr; w0 = o_data_wdata; b0 = o_data_be; we0 = o_data_we;
        end else if (a0 !== o_data_addr || w0 !== o_data_wdata || b0 !== o_data_be ||
                     we0 !== o_data_we) begin
          stable = 0;
        end
        if (req_seen == o.gnt_dly) begin
          i_data_gnt = 1'b1;
          if (!o.wr_en) in_wait = 1;
        end
        req_seen++;
      end else begin
        if (o_data_be !== 4'b0000 || o_data_wdata !== 32'h0) idle_zero = 0;
        if (in_wait) begin
          if (wait_seen == o.rv_dly) i_data_rvalid = 1'b1;
          wait_seen++;
        end else begin
          i_data_rvalid = o.noise;
        end
      end
      @(negedge i_clk);
      if (o_stall) stall_cnt++;
      else done = 1;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_data_gnt = 1'b0;
    i_data_rvalid = 1'b0;
    chk({nm, " completed"}, 64'(done), 64'd1);
    chk({nm, " req issued"}, 64'(req_seen > 0), 64'(e.req));
    if (e.req && req_seen > 0) begin
      chk({nm, " we"}, 64'(we0), 64'(e.we));
      chk({nm, " addr"}, 64'(a0), 64'(e.addr));
      chk({nm, " be"}, 64'(b0), 64'(e.be));
      chk({nm, " wdata"}, 64'(w0), 64'(e.wdata));
      chk({nm, " req stable"}, 64'(stable), 64'd1);
    end
    chk({nm, " be/wdata zero without req"}, 64'(idle_zero), 64'd1);
    chk({nm, " stall cycles"}, 64'(stall_cnt), 64'(e.stall));
    chk({nm, " wb_valid"}, 64'(o_wb_valid), 64'd1);
    chk({nm, " alu_result"}, 64'(o_alu_result), 64'(o.addr));
    chk({nm, " reg_write"}, 64'(o_reg_write), 64'(e.rw));
    chk({nm, " misaligned"}, 64'(o_misaligned), 64'(e.mis));
    chk({nm, " rd_data"}, 64'(o_data_rd_data), 64'(e.rd_data));
    chk({nm, " passthru"}, {o_imm, o_pc_plus_4},
        {o.imm, o.pc4});
    chk({nm, " ctrl"}, 64'({o_rd, o_d_size, o_d_unsigned, o_mem_to_reg}),
        64'({o.rd, o.size, o.uns, o.m2r}));
    if (gap) begin
      idle_inputs();
      @(posedge i_clk);
      #1;
      chk({nm, " wb_valid pulse ends"}, 64'({o_wb_valid, o_reg_write, o_data_req}), 64'd0);
    end
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    exp_t e;
    logic [3:0] sizes[3];
    sizes[0] = 4'b0001; sizes[1] = 4'b0011; sizes[2] = 4'b1111;

    vecs[0].name = "ld_byte_1003";
    vecs[0].op = mk_op(1, 0, 4'b0001, 32'h1003, 32'h0, 1, 2, 0, 32'hAABBCCDD);
    vecs[0].ex = mk_exp(1, 0, 32'h1000, 4'b1000, 32'h0, 0, 4, 32'hAABBCCDD, 1);
    vecs[1].name = "st_half_2002";
    vecs[1].op = mk_op(0, 1, 4'b0011, 32'h2002, 32'h12345678, 0, 0, 0, 32'h0);
    vecs[1].ex = mk_exp(1, 1, 32'h2000, 4'b1100, 32'h56785678, 0, 1, 32'h0, 0);
    vecs[2].name = "ld_word_misal";
    vecs[2].op = mk_op(1, 0, 4'b1111, 32'h3001, 32'h0, 1, 0, 0, 32'h0);
    vecs[2].ex = mk_exp(0, 0, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h0, 0);
    vecs[3].name = "alu_55";
    vecs[3].op = mk_op(0, 0, 4'b1111, 32'h55, 32'h0, 1, 0, 0, 32'h0);
    vecs[3].ex = mk_exp(0, 0, 32'h0, 4'b0000, 32'h0, 0, 0, 32'h0, 1);
    vecs[4].name = "rw_both_byte";
    vecs[4].op = mk_op(1, 1, 4'b0001, 32'h5001, 32'h000000A5, 0, 1, 0, 32'h99887766);
    vecs[4].ex = mk_exp(1, 1, 32'h5000, 4'b0010, 32'hA5A5A5A5, 0, 2, 32'h0, 0);
    vecs[5].name = "st_half_misal";
    vecs[5].op = mk_op(0, 1, 4'b0011, 32'h6001, 32'h1111, 1, 0, 0, 32'h0);
    vecs[5].ex = mk_exp(0, 1, 32'h0, 4'b0000, 32'h0, 1, 0, 32'h0, 0);
    vecs[6].name = "ld_half_7002";
    vecs[6].op = mk_op(1, 0, 4'b0011, 32'h7002, 32'hFFFF0000, 1, 1, 2, 32'h11223344);
    vecs[6].ex = mk_exp(1, 0, 32'h7000, 4'b1100, 32'h00000000, 0, 5, 32'h11223344, 1);

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset outputs", 64'({o_wb_valid, o_data_req, o_stall, o_data_be, o_reg_write,
                              o_misaligned}), 64'd0);
    chk("reset alu_result", 64'(o_alu_result), 64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("idle no req", 64'({o_data_req, o_wb_valid}), 64'd0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].ex, 1'b1);

    // Back-to-back store then load, each with grant withheld for 3 cycles
    o = mk_op(0, 1, 4'b1111, 32'h8000, 32'hCAFEBABE, 0, 3, 0, 32'h0);
    run_op("b2b_store", o, model(o), 1'b0);
    o = mk_op(1, 0, 4'b0011, 32'h8006, 32'h0, 1, 3, 1, 32'h55AA66BB);
    run_op("b2b_load", o, model(o), 1'b1);

    // Reset while waiting for load data
    o = mk_op(0, 0, 4'b1111, 32'h0BAD_0004, 32'h0, 1, 0, 0, 32'h0);
    run_op("pre_reset_alu", o, model(o), 1'b1);
    o = mk_op(1, 0, 4'b1111, 32'h4000, 32'h0, 1, 0, 0, 32'hDEADBEEF);
    drive_op(o);
    @(posedge i_clk);
    #1;
    i_data_gnt = 1'b1;
    @(posedge i_clk);
    #1;
    i_data_gnt = 1'b0;
    #1;
    chk("wait stall", 64'({o_stall, o_data_req}), 64'b10);
    i_rst_n = 1'b0;
    #1;
    chk("rst stall/req", 64'({o_stall, o_data_req, o_wb_valid}), 64'd0);
    chk("rst wb fields", {o_alu_result, o_pc_plus_4}, 64'd0);
    chk("rst wb fields2", 64'({o_imm, o_rd, o_reg_write}), 64'd0);
    idle_inputs();
    i_data_rdata = 32'hDEADBEEF;
    i_data_rvalid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    i_data_rvalid = 1'b0;
    chk("late rvalid ignored", 64'({o_wb_valid, o_stall, o_data_req}), 64'd0);
    chk("late rdata ignored", 64'(o_data_rd_data), 64'd0);
    o = mk_op(1, 0, 4'b0001, 32'h4002, 32'h0, 1, 1, 1, 32'h0A0B0C0D);
    run_op("post_reset_load", o, model(o), 1'b1);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      o = mk_op(kind == 1 || kind == 3, kind >= 2, sizes[$urandom_range(0, 2)],
                $urandom(), $urandom(), 1'($urandom()), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom());
      o.imm = $urandom();
      o.pc4 = $urandom();
      o.rd = 5'($urandom());
      o.uns = 1'($urandom());
      o.m2r = 3'($urandom());
      o.noise = 1'($urandom());
      run_op($sformatf("rand%0d", i), o, model(o), (i == 39) ? 1'b1 : 1'($urandom()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_mem_stage.md
CORE_MEM_STAGE -- requirements
Module: core_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have ports, clock and reset first: i_clk in 1 (single clock, all state on rising edge); i_rst_n in 1 (reset, asynchronous, active-low).
REQ-003 SHALL have pipeline inputs: i_valid 1 (EX op valid); i_mem_read 1; i_mem_write 1; i_d_size 4 (0001 byte, 0011 half, 1111 word); i_d_unsigned 1; i_mem_to_reg 3; i_alu_result XLEN (effective address / ALU value); i_rs2_data XLEN (store data); i_imm XLEN; i_pc_plus_4 XLEN; i_rd 5; i_reg_write 1.
REQ-004 SHALL have o_stall out 1: hold EX/MEM inputs stable while high.
REQ-005 SHALL have data-memory outputs: o_data_req 1; o_data_we 1; o_data_addr XLEN (word-aligned, [1:0]=00); o_data_be 4; o_data_wdata XLEN.
REQ-006 SHALL have data-memory inputs: i_data_gnt 1 (request accepted); i_data_rvalid 1 (load data valid); i_data_rdata XLEN.
REQ-007 SHALL have registered WB-side outputs: o_wb_valid 1; o_d_size 4; o_d_unsigned 1; o_mem_to_reg 3; o_data_rd_data XLEN; o_imm XLEN; o_pc_plus_4 XLEN; o_alu_result XLEN; o_rd 5; o_reg_write 1; o_misaligned 1.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-009 A non-memory op (i_valid, neither read nor write) in IDLE SHALL register all pass-through fields to WB outputs on the next edge with o_wb_valid=1: latency 1, o_stall=0.
REQ-010 A memory op in IDLE SHALL be misaligned when half and addr[0]=1, or word and addr[1:0]!=00; byte is never misaligned.
REQ-011 A misaligned op SHALL issue no request, SHALL pass through as in REQ-009 with o_misaligned=1 and o_reg_write forced 0, and SHALL leave o_stall=0.
REQ-012 An aligned memory op in IDLE SHALL drive o_stall=1 combinationally, latch address/data/controls, and go to REQ.
REQ-013 In REQ: o_data_req=1, o_data_we=latched write, o_data_addr={addr[XLEN-1:2],2'b00}; all request signals SHALL stay constant until i_data_gnt.
REQ-014 o_data_be: byte = 0001 << addr[1:0]; half = 0011 << {addr[1],0}; word = 1111; o_data_be SHALL be 0000 and o_data_wdata SHALL be 0 while o_data_req=0.
REQ-015 o_data_wdata: byte = {4{rs2[7:0]}}; half = {2{rs2[15:0]}}; word = rs2.
REQ-016 REQ with i_data_gnt: a store SHALL complete (o_stall=0 that cycle, WB outputs registered, go to IDLE); a load SHALL go to WAIT with o_stall held 1.
REQ-017 i_data_rvalid SHALL be ignored outside WAIT; memory returns rvalid no earlier than the cycle after gnt.
REQ-018 WAIT with i_data_rvalid: o_stall=0 that cycle; o_data_rd_data SHALL register i_data_rdata unshifted, with o_alu_result carrying the full address so WB extracts lanes; then go to IDLE.
REQ-019 Each completion SHALL pulse o_wb_valid for exactly one cycle; in every non-completing cycle o_wb_valid=0 and o_reg_write=0.
REQ-020 An op with both i_mem_read and i_mem_write SHALL be treated as a store.
REQ-021 i_valid=0 in IDLE SHALL produce no request and o_wb_valid=0 next cycle.

Reset
REQ-022 i_rst_n low SHALL immediately force state IDLE, o_data_req=0, o_stall=0, and every registered output to 0, including mid-REQ and mid-WAIT.
REQ-023 A gnt or rvalid arriving while reset is asserted, or for an op aborted by reset, SHALL be discarded.

Verification
REQ-024 SHALL check a load byte at addr 0x1003, gnt after 2 cycles, rvalid 1 cycle later with rdata 0xAABBCCDD: be=1000, addr 0x1000, o_stall high for 4 cycles, o_data_rd_data=0xAABBCCDD, o_wb_valid one pulse.
REQ-025 SHALL check a store half at addr 0x2002 with rs2 0x12345678 and immediate gnt: be=1100, wdata 0x56785678, we=1, completes in the gnt cycle.
REQ-026 SHALL check a load word at 0x3001: no o_data_req, o_misaligned=1, o_reg_write=0, o_stall=0.
REQ-027 SHALL check an ALU op with alu_result 0x55: o_alu_result=0x55 and o_wb_valid=1 one cycle later, no request.
REQ-028 SHALL check reset asserted in WAIT: outputs zero immediately, a later rvalid is ignored, and the next op proceeds normally.
REQ-029 SHALL check back-to-back store then load with gnt held low 3 cycles: request signals stable throughout and both ops complete in order.
